// File: rtl/req_arbiter_4.sv
// Four-requester arbiter for a shared resource. Supports fixed-priority or
// round-robin selection, registered one-hot grant with binary id, and an
// optional hold timeout that force-releases long grants.
module req_arbiter_4 #(
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last grant cycle before a forced release. With the timeout disabled it
    // equals the counter maximum, so the same constant doubles as the
    // saturation point and the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_TOP = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [1:0]       id_q, id_n;
    logic [1:0]       last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       gnt_q, gnt_n;
    logic             to_q, to_n;

    logic [1:0]       win_id;
    logic             win_found;
    logic [1:0]       rr_idx;

    // Winner selection from the current request vector.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        rr_idx    = '0;
        if (RR_EN != 0) begin
            for (int unsigned i = 1; i <= 4; i++) begin
                rr_idx = last_q + i[1:0];
                if (!win_found && req[rr_idx]) begin
                    win_found = 1'b1;
                    win_id    = rr_idx;
                end
            end
        end else begin
            // Ascending scan: the highest set index is written last and wins.
            for (int unsigned i = 0; i < 4; i++) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_id    = i[1:0];
                end
            end
        end
    end

    // Next-state, hold counter and registered-output values.
    always_comb begin
        state_n = state;
        id_n    = id_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        to_n    = 1'b0;
        gnt_n   = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = GRANT;
                    id_n    = win_id;
                    last_n  = win_id;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (done || !req[id_q]) begin
                    state_n = IDLE;
                end else if ((MAX_HOLD != 0) && (cnt_q == CNT_TOP)) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end else if (cnt_q != CNT_TOP) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n == GRANT) begin
            gnt_n[id_n] = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            id_q   <= '0;
            last_q <= 2'd3;
            cnt_q  <= '0;
            gnt_q  <= '0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_n;
            id_q   <= id_n;
            last_q <= last_n;
            cnt_q  <= cnt_n;
            gnt_q  <= gnt_n;
            to_q   <= to_n;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign gnt_vld = |gnt_q;
    assign timeout = to_q;

endmodule
